// File: rtl/delay_tap_ctrl_pkg.sv
// Shared types and constants for the delay-chain tap calibration controller.
package delay_tap_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_LAUNCH,
        S_MEASURE,
        S_EVAL,
        S_DONE
    } state_t;

    // Cycles added to a tap's arrival time by the chain_o synchroniser.
    localparam int unsigned SYNC_LAT = 2;

endpackage

// File: rtl/delay_tap_ctrl_sync2.sv
// Two-flop synchroniser for a single asynchronous input; both flops clear to 0.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/delay_tap_ctrl.sv
// Calibrates an external tapped delay chain: measures each tap's launch-to-arrival
// latency and linearly searches for the shortest tap that meets a target.
module delay_tap_ctrl
    import delay_tap_pkg::*;
#(
    parameter int unsigned NTAP       = 16,
    parameter int unsigned TW         = 4,
    parameter int unsigned CW         = 8,
    parameter int unsigned TMAX       = 255,
    parameter int unsigned CLR_CYC    = 4,
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic        RPOL       = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] target,
    output logic          chain_i,
    output logic          chain_rst,
    output logic [TW-1:0] tap_sel,
    input  logic          chain_o,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [CW-1:0] meas
);

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] mres;
    logic [CW-1:0] tgt;
    logic          arrived;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (chain_o),
        .q   (arrived)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (start) nxt = S_CLEAR;
            S_CLEAR:   if (cnt == CW'(CLR_CYC - 1)) nxt = S_SETTLE;
            S_SETTLE:  if (cnt == CW'(SETTLE_CYC - 1)) nxt = S_LAUNCH;
            S_LAUNCH:  nxt = S_MEASURE;
            S_MEASURE: if (arrived || cnt == CW'(TMAX - 1)) nxt = S_EVAL;
            S_EVAL: begin
                if (mres >= tgt || tap_sel == TW'(NTAP - 1)) nxt = S_DONE;
                else                                          nxt = S_CLEAR;
            end
            S_DONE:    nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge
    // as the state. cnt keeps running from LAUNCH into MEASURE, so during cycle
    // L+j it holds j and the latency at the exit edge is cnt+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_i   <= 1'b0;
            chain_rst <= RPOL;
            tap_sel   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            meas      <= '0;
            cnt       <= '0;
            mres      <= '0;
            tgt       <= '0;
        end else begin
            chain_i   <= (nxt inside {S_LAUNCH, S_MEASURE});
            chain_rst <= (nxt inside {S_SETTLE, S_LAUNCH, S_MEASURE, S_EVAL}) ? ~RPOL : RPOL;
            busy      <= (nxt != S_IDLE);
            done      <= (nxt == S_DONE);

            if (state == S_IDLE || (nxt != state && state != S_LAUNCH)) cnt <= '0;
            else                                                          cnt <= cnt + 1'b1;

            if (state == S_MEASURE) mres <= cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        tgt     <= target;
                        tap_sel <= '0;
                        found   <= 1'b0;
                        meas    <= '0;
                    end
                end
                S_EVAL: begin
                    meas  <= mres;
                    found <= (mres >= tgt);
                    if (nxt == S_CLEAR) tap_sel <= tap_sel + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_tap_ctrl.sv
// Directed bench for delay_tap_ctrl driving an ideal synchronous delay-chain model
// in which tap k's output rises k+1 edges after launch.
module tb_delay_tap_ctrl;
    import delay_tap_pkg::*;

    localparam int unsigned NTAP = 16;
    localparam int unsigned TW   = 4;
    localparam int unsigned CW   = 8;
    localparam int unsigned TMAX = 255;
    localparam logic        RPOL = 1'b1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] target;
    logic          chain_i;
    logic          chain_rst;
    logic [TW-1:0] tap_sel;
    logic          chain_o = 1'b0;
    logic          busy;
    logic          done;
    logic          found;
    logic [CW-1:0] meas;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    delay_tap_ctrl #(
        .NTAP(NTAP), .TW(TW), .CW(CW), .TMAX(TMAX),
        .CLR_CYC(4), .SETTLE_CYC(2), .RPOL(RPOL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .target(target),
        .chain_i(chain_i), .chain_rst(chain_rst), .tap_sel(tap_sel),
        .chain_o(chain_o), .busy(busy), .done(done), .found(found), .meas(meas)
    );

    // Chain model: output seen high at edge L+d, d = tap_sel+1; cleared by chain reset.
    logic stuck    = 1'b0;
    logic launched = 1'b0;
    int   n        = 0;
    always @(negedge clk) begin
        if (chain_rst == RPOL) begin
            launched <= 1'b0;
            n        <= 0;
            chain_o  <= 1'b0;
        end else if (launched) begin
            n       <= n + 1;
            chain_o <= !stuck && (n + 2 >= int'(tap_sel) + 1);
        end else if (chain_i) begin
            launched <= 1'b1;
            n        <= 0;
            chain_o  <= !stuck && (1 >= int'(tap_sel) + 1);
        end
    end

    // Sequencing monitor: reset/settle run lengths before each launch, launch count,
    // and the length of the last chain_i high pulse.
    int   rst_run = 0, set_run = 0, hi_run = 0, last_hi = 0;
    int   launches = 0, seq_err = 0, ovl_err = 0;
    logic rel = 1'b0, prev_ci = 1'b0;
    always @(negedge clk) begin
        prev_ci <= chain_i;
        if (!busy) begin
            rst_run <= 0;
            set_run <= 0;
            hi_run  <= 0;
            rel     <= 1'b0;
        end else if (chain_rst == RPOL) begin
            rst_run <= rel ? 1 : rst_run + 1;
            set_run <= 0;
            rel     <= 1'b0;
        end else if (!chain_i) begin
            set_run <= set_run + 1;
            rel     <= 1'b1;
            hi_run  <= 0;
            if (prev_ci) last_hi <= hi_run;
        end else begin
            rel    <= 1'b1;
            hi_run <= hi_run + 1;
            if (!prev_ci) begin
                launches <= launches + 1;
                if (rst_run != 4 || set_run != 2) seq_err <= seq_err + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chain_i && chain_rst == RPOL) ovl_err <= ovl_err + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run(input string nm, input logic [CW-1:0] tg, input logic stk,
                       input bit noise, input int e_found, input int e_tap,
                       input int e_meas, input int e_n);
        int  l0, s0;
        bit  got;
        stuck = stk;
        l0 = launches;
        s0 = seq_err + ovl_err;
        got = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        target = tg;
        @(negedge clk);
        start = 1'b0;
        chk({nm, ".busy"}, int'(busy), 1);
        for (int c = 0; c < 3000; c++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            start = noise && (c % 7 == 3);
            if (start) target = '0;
            @(negedge clk);
        end
        chk({nm, ".done_seen"}, int'(got), 1);
        chk({nm, ".found"}, int'(found), e_found);
        chk({nm, ".tap"}, int'(tap_sel), e_tap);
        chk({nm, ".meas"}, int'(meas), e_meas);
        chk({nm, ".taps_tried"}, launches - l0, e_n);
        chk({nm, ".seq_err"}, seq_err + ovl_err - s0, 0);
        chk({nm, ".launch_width"}, last_hi, e_meas);
        start = noise;
        @(negedge clk);
        start = 1'b0;
        chk({nm, ".done_width"}, int'(done), 0);
        chk({nm, ".busy_after"}, int'(busy), 0);
        chk({nm, ".meas_held"}, int'(meas), e_meas);
        chk({nm, ".tap_held"}, int'(tap_sel), e_tap);
        if (noise) begin
            @(negedge clk);
            chk({nm, ".start_at_done_ignored"}, int'(busy), 0);
        end
    endtask

    typedef struct {
        logic [CW-1:0] tg;
        logic          stk;
        int            f;
        int            tap;
        int            m;
        int            n;
    } vec_t;

    vec_t vt[10];

    initial begin
        bit reached;
        vt[0] = '{tg: 8'd6,   stk: 1'b0, f: 1, tap: 3,  m: 6,   n: 4};
        vt[1] = '{tg: 8'd40,  stk: 1'b0, f: 0, tap: 15, m: 18,  n: 16};
        vt[2] = '{tg: 8'd0,   stk: 1'b0, f: 1, tap: 0,  m: 3,   n: 1};
        vt[3] = '{tg: 8'd3,   stk: 1'b0, f: 1, tap: 0,  m: 3,   n: 1};
        vt[4] = '{tg: 8'd4,   stk: 1'b0, f: 1, tap: 1,  m: 4,   n: 2};
        vt[5] = '{tg: 8'd18,  stk: 1'b0, f: 1, tap: 15, m: 18,  n: 16};
        vt[6] = '{tg: 8'd19,  stk: 1'b0, f: 0, tap: 15, m: 18,  n: 16};
        vt[7] = '{tg: 8'd10,  stk: 1'b1, f: 1, tap: 0,  m: 255, n: 1};
        vt[8] = '{tg: 8'd255, stk: 1'b1, f: 1, tap: 0,  m: 255, n: 1};
        vt[9] = '{tg: 8'd200, stk: 1'b0, f: 0, tap: 15, m: 18,  n: 16};

        rst    = 1'b1;
        start  = 1'b0;
        target = '0;
        repeat (3) @(negedge clk);
        chk("rst.chain_rst", int'(chain_rst), int'(RPOL));
        chk("rst.chain_i", int'(chain_i), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.found", int'(found), 0);
        chk("rst.meas", int'(meas), 0);
        chk("rst.tap", int'(tap_sel), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.chain_rst", int'(chain_rst), int'(RPOL));

        for (int i = 0; i < 10; i++)
            run($sformatf("v%0d", i), vt[i].tg, vt[i].stk, 1'b0,
                vt[i].f, vt[i].tap, vt[i].m, vt[i].n);

        run("noise", 8'd6, 1'b0, 1'b1, 1, 3, 6, 4);

        // Abort with reset in the middle of tap 5's measurement.
        stuck = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        target = 8'd40;
        @(negedge clk);
        start   = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (tap_sel == TW'(5) && chain_i) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("abort.reach_tap5", int'(reached), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.chain_rst", int'(chain_rst), int'(RPOL));
        chk("abort.chain_i", int'(chain_i), 0);
        chk("abort.busy", int'(busy), 0);
        chk("abort.tap", int'(tap_sel), 0);
        chk("abort.done", int'(done), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort.no_done", int'(done), 0);
        end
        rst = 1'b0;
        run("after_abort", 8'd6, 1'b0, 1'b0, 1, 3, 6, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
